// File: rtl/cmos_spot_locator.sv
// cmos_spot_locator: per-frame bright-spot bounding box and pixel count, latched at frame end for byte-wise MCU reads.
// Build option SPOT_RUN_FILTER_EN: a pixel counts only when it and the previous pixel of its line are both bright.
module cmos_spot_locator #(
    parameter int PIX_W = 8,
    parameter int COL_W = 10,
    parameter int ROW_W = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             cmos_vsync,
    input  logic             cmos_hsync,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_cmos,
    input  logic [PIX_W-1:0] thresh,
    output logic             frame_start,
    output logic             column_start,
    output logic             frame_done,
    output logic             spot_found,
    input  logic             mcu_rd_en,
    input  logic [3:0]       mcu_addr,
    output logic [7:0]       mcu_data
);
    typedef enum logic [1:0] {IDLE, FRAME, LATCH} state_t;
    state_t r_state, w_next;
    logic r_vs_d, r_hs_d, r_ovf, r_res_ovf, r_seq;
    logic w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall, w_start, w_col_start, w_latch;
    logic w_in_frame, w_pix, w_hot, w_bright, w_col_max, w_row_max;
    logic [COL_W-1:0] r_col, r_xmin, r_xmax, r_res_xmin, r_res_xmax, w_col;
    logic [ROW_W-1:0] r_row, r_ymin, r_ymax, r_res_ymin, r_res_ymax;
    logic [CNT_W-1:0] r_cnt, r_res_cnt;
    logic [15:0] w_xmin, w_xmax, w_ymin, w_ymax, w_cnt;
    logic [7:0] w_rd;

    assign w_vs_rise  = cmos_vsync & ~r_vs_d;
    assign w_vs_fall  = ~cmos_vsync & r_vs_d;
    assign w_hs_rise  = cmos_hsync & ~r_hs_d;
    assign w_hs_fall  = ~cmos_hsync & r_hs_d;
    assign w_in_frame = (r_state == FRAME);
    assign w_pix      = w_in_frame & pix_valid & cmos_hsync;
    // a pixel arriving on the hsync rise cycle belongs to column 0
    assign w_col      = w_hs_rise ? '0 : r_col;
    assign w_col_max  = &w_col;
    assign w_row_max  = &r_row;
    assign w_hot      = (pix_cmos >= thresh);

`ifdef SPOT_RUN_FILTER_EN
    logic r_run;
    assign w_bright = w_pix & w_hot & r_run & ~w_hs_rise;
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            r_run <= 1'b0;
        else if (w_pix)
            r_run <= w_hot;
        else if (w_hs_rise)
            r_run <= 1'b0;
    end
`else
    assign w_bright = w_pix & w_hot;
`endif

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_col_start = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = w_vs_rise;
                w_next  = w_vs_rise ? FRAME : IDLE;
            end
            FRAME: begin
                w_col_start = w_hs_rise;
                w_next      = w_vs_fall ? LATCH : FRAME;
            end
            default: begin
                w_latch = 1'b1;
                w_start = w_vs_rise;
                w_next  = w_vs_rise ? FRAME : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state      <= IDLE;
            frame_start  <= 1'b0;
            column_start <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            r_state      <= w_next;
            frame_start  <= w_start;
            column_start <= w_col_start;
            frame_done   <= w_latch;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_vs_d     <= 1'b0;
            r_hs_d     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_cnt      <= '0;
            r_xmin     <= '1;
            r_xmax     <= '0;
            r_ymin     <= '1;
            r_ymax     <= '0;
            r_ovf      <= 1'b0;
            r_res_xmin <= '1;
            r_res_xmax <= '0;
            r_res_ymin <= '1;
            r_res_ymax <= '0;
            r_res_cnt  <= '0;
            r_res_ovf  <= 1'b0;
            r_seq      <= 1'b0;
            spot_found <= 1'b0;
            mcu_data   <= 8'h00;
        end else begin
            r_vs_d <= cmos_vsync;
            r_hs_d <= cmos_hsync;
            if (w_start) begin
                r_col  <= '0;
                r_row  <= '0;
                r_cnt  <= '0;
                r_xmin <= '1;
                r_xmax <= '0;
                r_ymin <= '1;
                r_ymax <= '0;
                r_ovf  <= 1'b0;
            end else if (w_in_frame) begin
                if (w_pix)
                    r_col <= w_col_max ? w_col : w_col + 1'b1;
                else if (w_hs_rise | w_hs_fall)
                    r_col <= '0;
                if (w_hs_fall)
                    r_row <= w_row_max ? r_row : r_row + 1'b1;
                r_ovf <= r_ovf | (w_pix & w_col_max) | (w_hs_fall & w_row_max);
                if (w_bright) begin
                    r_xmin <= (w_col < r_xmin) ? w_col : r_xmin;
                    r_xmax <= (w_col > r_xmax) ? w_col : r_xmax;
                    r_ymin <= (r_row < r_ymin) ? r_row : r_ymin;
                    r_ymax <= (r_row > r_ymax) ? r_row : r_ymax;
                    r_cnt  <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                end
            end
            if (w_latch) begin
                r_res_xmin <= r_xmin;
                r_res_xmax <= r_xmax;
                r_res_ymin <= r_ymin;
                r_res_ymax <= r_ymax;
                r_res_cnt  <= r_cnt;
                r_res_ovf  <= r_ovf;
                spot_found <= (r_cnt != '0);
                r_seq      <= ~r_seq;
            end
            // sampled before this edge's latch, so a coinciding read sees the old frame
            if (mcu_rd_en)
                mcu_data <= w_rd;
        end
    end

    assign w_xmin = 16'(r_res_xmin);
    assign w_xmax = 16'(r_res_xmax);
    assign w_ymin = 16'(r_res_ymin);
    assign w_ymax = 16'(r_res_ymax);
    assign w_cnt  = 16'(r_res_cnt);

    always_comb begin
        w_rd = 8'h00;
        case (mcu_addr)
            4'd0:    w_rd = {5'b0, r_seq, r_res_ovf, spot_found};
            4'd1:    w_rd = w_xmin[7:0];
            4'd2:    w_rd = w_xmin[15:8];
            4'd3:    w_rd = w_xmax[7:0];
            4'd4:    w_rd = w_xmax[15:8];
            4'd5:    w_rd = w_ymin[7:0];
            4'd6:    w_rd = w_ymin[15:8];
            4'd7:    w_rd = w_ymax[7:0];
            4'd8:    w_rd = w_ymax[15:8];
            4'd9:    w_rd = w_cnt[7:0];
            4'd10:   w_rd = w_cnt[15:8];
            default: w_rd = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_cmos_spot_locator.sv
// tb_cmos_spot_locator: drives pixel frames into a default and a 3-bit-column instance and
// checks latched results against a per-pixel reference model of the bright-spot rules.
module tb_cmos_spot_locator;
    logic clk = 1'b0, nRst = 1'b0, cmos_vsync = 1'b0, cmos_hsync = 1'b0, pix_valid = 1'b0, mcu_rd_en = 1'b0;
    logic [7:0] pix_cmos = 8'h00, thresh = 8'h00;
    logic [3:0] mcu_addr = 4'h0;
    logic fs_b, cs_b, fd_b, sf_b, fs_s, cs_s, fd_s, sf_s;
    logic [7:0] md_b, md_s;
    int total = 0, bad = 0;
    int n_done = 0, n_start = 0, n_col = 0, n_both = 0, n_skew = 0, nframes = 0;
    int pix [16][16];
    int fw, fh;

    always #5 clk = ~clk;

    cmos_spot_locator u_big (
        .clk(clk), .nRst(nRst), .cmos_vsync(cmos_vsync), .cmos_hsync(cmos_hsync),
        .pix_valid(pix_valid), .pix_cmos(pix_cmos), .thresh(thresh),
        .frame_start(fs_b), .column_start(cs_b), .frame_done(fd_b), .spot_found(sf_b),
        .mcu_rd_en(mcu_rd_en), .mcu_addr(mcu_addr), .mcu_data(md_b)
    );

    cmos_spot_locator #(.COL_W(3)) u_small (
        .clk(clk), .nRst(nRst), .cmos_vsync(cmos_vsync), .cmos_hsync(cmos_hsync),
        .pix_valid(pix_valid), .pix_cmos(pix_cmos), .thresh(thresh),
        .frame_start(fs_s), .column_start(cs_s), .frame_done(fd_s), .spot_found(sf_s),
        .mcu_rd_en(mcu_rd_en), .mcu_addr(mcu_addr), .mcu_data(md_s)
    );

    always @(negedge clk) begin
        if (fd_b) n_done++;
        if (fs_b) n_start++;
        if (cs_b) n_col++;
        if (fs_b && fd_b) n_both++;
        if ({fs_s, cs_s, fd_s} !== {fs_b, cs_b, fd_b}) n_skew++;
    end

    // expected {status, xmin, xmax, ymin, ymax, count} straight from the pixel array
    function automatic logic [87:0] model(input int colw, input int seq);
        int cmax, xmin, xmax, ymin, ymax, cnt, x;
        bit b, ovf;
        cmax = (1 << colw) - 1;
        xmin = cmax; xmax = 0; ymin = 511; ymax = 0; cnt = 0;
        for (int r = 0; r < fh; r++)
            for (int c = 0; c < fw; c++) begin
                x = (c < cmax) ? c : cmax;
                b = pix[r][c] >= int'(thresh);
`ifdef SPOT_RUN_FILTER_EN
                if (c == 0) b = 0;
                else if (pix[r][c-1] < int'(thresh)) b = 0;
`endif
                if (b) begin
                    if (x < xmin) xmin = x;
                    if (x > xmax) xmax = x;
                    if (r < ymin) ymin = r;
                    if (r > ymax) ymax = r;
                    cnt++;
                end
            end
        ovf = (fw > cmax) || (fh > 511);
        return {5'b0, seq[0], ovf, cnt != 0, 16'(xmin), 16'(xmax), 16'(ymin), 16'(ymax), 16'(cnt)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) pix[r][c] = v;
    endtask

    task automatic rd(input int a, output logic [7:0] d0, output logic [7:0] d1);
        mcu_rd_en = 1'b1;
        mcu_addr  = 4'(a);
        tick();
        mcu_rd_en = 1'b0;
        d0 = md_b;
        d1 = md_s;
    endtask

    task automatic read_all(output logic [87:0] rb, output logic [87:0] rs);
        logic [7:0] b [11];
        logic [7:0] s [11];
        for (int a = 0; a < 11; a++) rd(a, b[a], s[a]);
        rb = {b[0], b[2], b[1], b[4], b[3], b[6], b[5], b[8], b[7], b[10], b[9]};
        rs = {s[0], s[2], s[1], s[4], s[3], s[6], s[5], s[8], s[7], s[10], s[9]};
    endtask

    task automatic frame_body();
        tick();
        for (int r = 0; r < fh; r++) begin
            cmos_hsync = 1'b1;
            tick();
            for (int c = 0; c < fw; c++) begin
                pix_valid = 1'b1;
                pix_cmos  = 8'(pix[r][c]);
                tick();
                if ($urandom_range(0, 3) == 0) begin
                    pix_valid = 1'b0;
                    pix_cmos  = 8'($urandom);
                    tick();
                end
            end
            pix_valid  = 1'b0;
            cmos_hsync = 1'b0;
            tick();
            pix_valid = 1'b1;
            pix_cmos  = 8'hFF;
            tick();
            pix_valid = 1'b0;
            tick();
        end
    endtask

    task automatic run_frame();
        cmos_vsync = 1'b1;
        frame_body();
        cmos_vsync = 1'b0;
        repeat (4) tick();
        nframes++;
    endtask

    task automatic test_reset();
        logic [7:0] b, s, e;
        nRst = 1'b0;
        repeat (3) tick();
        nRst = 1'b1;
        tick();
        total++;
        if ({fs_b, cs_b, fd_b, sf_b, md_b} !== 12'h0) begin
            bad++;
            $display("FAIL reset_pins got=%h want=000", {fs_b, cs_b, fd_b, sf_b, md_b});
        end
        for (int a = 0; a < 16; a++) begin
            rd(a, b, s);
            e = (a == 1 || a == 5) ? 8'hFF : (a == 2) ? 8'h03 : (a == 6) ? 8'h01 : 8'h00;
            total++;
            if (b !== e) begin
                bad++;
                $display("FAIL reset_addr%0d got=%h want=%h", a, b, e);
            end
        end
        rd(1, b, s);
        repeat (3) tick();
        total++;
        if ({md_b, s} !== 16'hFF07) begin
            bad++;
            $display("FAIL reset_hold_small_xmin got=%h want=ff07", {md_b, s});
        end
    endtask

    task automatic test_single_spot();
        logic [87:0] rb, rs, eb;
        int d0, s0, c0;
        fw = 8; fh = 4; thresh = 8'd200;
        fill(0);
        pix[1][3] = 250;
        eb = model(10, nframes + 1);
        d0 = n_done; s0 = n_start; c0 = n_col;
        run_frame();
        read_all(rb, rs);
        total++;
        if ({n_done - d0, n_start - s0, n_col - c0} !== {32'd1, 32'd1, 32'd4}) begin
            bad++;
            $display("FAIL spot_pulses done=%0d start=%0d col=%0d want=1/1/4", n_done - d0, n_start - s0, n_col - c0);
        end
        total++;
        if (rb !== eb) begin
            bad++;
            $display("FAIL spot_regs got=%h want=%h", rb, eb);
        end
        total++;
        if (sf_b !== eb[80]) begin
            bad++;
            $display("FAIL spot_found_pin got=%b want=%b", sf_b, eb[80]);
        end
`ifndef SPOT_RUN_FILTER_EN
        total++;
        if ({rb[82], rb[79:0]} !== {1'b1, 16'd3, 16'd3, 16'd1, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL spot_bbox got=%h want=seq1 3,3,1,1 cnt1", {rb[82], rb[79:0]});
        end
`endif
    endtask

    task automatic test_empty();
        logic [87:0] rb, rs, eb;
        fw = 8; fh = 4; thresh = 8'd200;
        fill(100);
        eb = model(10, nframes + 1);
        run_frame();
        read_all(rb, rs);
        total++;
        if (rb !== eb) begin
            bad++;
            $display("FAIL empty_regs got=%h want=%h", rb, eb);
        end
        total++;
        if ({sf_b, rb[80], rb[79:0]} !== {2'b00, 16'h03FF, 16'h0, 16'h01FF, 16'h0, 16'h0}) begin
            bad++;
            $display("FAIL empty_fields got=%h", {sf_b, rb[80], rb[79:0]});
        end
    endtask

    task automatic test_block();
        logic [87:0] rb, rs, eb;
        fw = 10; fh = 6; thresh = 8'd200;
        fill(0);
        for (int r = 2; r < 4; r++)
            for (int c = 5; c < 7; c++) pix[r][c] = 230;
        eb = model(10, nframes + 1);
        run_frame();
        read_all(rb, rs);
        total++;
        if (rb !== eb) begin
            bad++;
            $display("FAIL block_regs got=%h want=%h", rb, eb);
        end
        total++;
`ifdef SPOT_RUN_FILTER_EN
        if ({rb[79:64], rb[15:0]} !== {16'd6, 16'd2}) begin
`else
        if ({rb[79:64], rb[15:0]} !== {16'd5, 16'd4}) begin
`endif
            bad++;
            $display("FAIL block_xmin_cnt got=%h", {rb[79:64], rb[15:0]});
        end
    endtask

    task automatic test_col_sat();
        logic [87:0] rb, rs, eb, es;
        fw = 10; fh = 2; thresh = 8'd200;
        fill(250);
        eb = model(10, nframes + 1);
        es = model(3, nframes + 1);
        run_frame();
        read_all(rb, rs);
        total++;
        if (rs !== es) begin
            bad++;
            $display("FAIL sat_small_regs got=%h want=%h", rs, es);
        end
        total++;
        if (rb !== eb) begin
            bad++;
            $display("FAIL sat_big_regs got=%h want=%h", rb, eb);
        end
        total++;
        if ({rs[81], rs[63:48], rb[81], rb[63:48]} !== {1'b1, 16'd7, 1'b0, 16'd9}) begin
            bad++;
            $display("FAIL sat_ovf_xmax got=%h", {rs[81], rs[63:48], rb[81], rb[63:48]});
        end
    endtask

    task automatic test_reset_mid();
        logic [87:0] rb, rs, eb;
        thresh = 8'd200;
        cmos_vsync = 1'b1;
        tick();
        cmos_hsync = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1;
            pix_cmos  = 8'd255;
            tick();
        end
        nRst = 1'b0;
        pix_valid = 1'b0; cmos_hsync = 1'b0; cmos_vsync = 1'b0;
        tick();
        nRst = 1'b1;
        nframes = 0;
        tick();
        fw = 0; fh = 0;
        eb = model(10, 0);
        read_all(rb, rs);
        total++;
        if (rb !== eb) begin
            bad++;
            $display("FAIL midreset_cleared got=%h want=%h", rb, eb);
        end
        fw = 4; fh = 2;
        fill(0);
        pix[0][0] = 250;
        eb = model(10, nframes + 1);
        run_frame();
        read_all(rb, rs);
        total++;
        if (rb !== eb) begin
            bad++;
            $display("FAIL midreset_frame got=%h want=%h", rb, eb);
        end
    endtask

    task automatic test_back_to_back();
        logic [87:0] rb, rs, eb, es;
        int b0, d0;
        fw = 6; fh = 3; thresh = 8'd128;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) pix[r][c] = $urandom_range(0, 255);
        eb = model(10, nframes + 1);
        es = model(3, nframes + 1);
        b0 = n_both; d0 = n_done;
        cmos_vsync = 1'b1;
        frame_body();
        cmos_vsync = 1'b0;
        tick();
        cmos_vsync = 1'b1;
        repeat (2) tick();
        nframes++;
        total++;
        if (n_both - b0 !== 1) begin
            bad++;
            $display("FAIL b2b_start_with_done got=%0d want=1", n_both - b0);
        end
        read_all(rb, rs);
        total++;
        if ({rb, rs} !== {eb, es}) begin
            bad++;
            $display("FAIL b2b_first got=%h/%h want=%h/%h", rb, rs, eb, es);
        end
        fw = 9; fh = 5;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) pix[r][c] = $urandom_range(0, 255);
        eb = model(10, nframes + 1);
        frame_body();
        cmos_vsync = 1'b0;
        repeat (4) tick();
        nframes++;
        read_all(rb, rs);
        total++;
        if (rb !== eb || n_done - d0 !== 2) begin
            bad++;
            $display("FAIL b2b_second got=%h done=%0d want=%h done=2", rb, n_done - d0, eb);
        end
    endtask

    task automatic test_random();
        logic [87:0] rb, rs, eb, es;
        for (int k = 0; k < 6; k++) begin
            fw = $urandom_range(2, 16);
            fh = $urandom_range(1, 8);
            thresh = 8'($urandom_range(100, 250));
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) pix[r][c] = $urandom_range(0, 255);
            eb = model(10, nframes + 1);
            es = model(3, nframes + 1);
            run_frame();
            read_all(rb, rs);
            total++;
            if (rb !== eb) begin
                bad++;
                $display("FAIL random%0d_big got=%h want=%h", k, rb, eb);
            end
            total++;
            if (rs !== es) begin
                bad++;
                $display("FAIL random%0d_small got=%h want=%h", k, rs, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_spot();
        test_empty();
        test_block();
        test_col_sat();
        test_reset_mid();
        test_back_to_back();
        test_random();
        total++;
        if (n_skew !== 0) begin
            bad++;
            $display("FAIL pulse_skew got=%0d want=0", n_skew);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
